// File: rtl/cdb_pkg.sv
// Shared constants, entry type and round-robin helper for the CDB arbiter.
package cdb_pkg;
  localparam int NUM_SRC        = 4;
  localparam int NUM_LANE       = 3;
  localparam int DATA_W_DEF     = 32;
  localparam int ROB_ID_W_DEF   = 5;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef struct packed {
    logic [ROB_ID_W_DEF-1:0] id_ROB;
    logic [DATA_W_DEF-1:0]   data;
  } cdb_entry_t;

  function automatic logic [1:0] rr_next(input logic [1:0] last_src);
    return last_src + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: power-of-two depth, wrap-around pointers, flush.
module cdb_src_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [W-1:0]                   i_data,
  output logic [W-1:0]                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Storage array, written on push only.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointer and occupancy state with asynchronous reset and synchronous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_ONE;
      if (i_pop)  r_rd <= r_rd + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/cdb_arbiter.sv
// Four-source, three-lane common data bus arbiter with per-source FIFOs.
// Optional same-cycle bypass of empty FIFOs when CDB_BYPASS_EN is defined.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_c,
  input  logic                rdy,
  input  logic                src0_en_i,
  input  logic [ROB_ID_W-1:0] src0_id_ROB_i,
  input  logic [DATA_W-1:0]   src0_data_i,
  output logic                src0_busy_o,
  input  logic                src1_en_i,
  input  logic [ROB_ID_W-1:0] src1_id_ROB_i,
  input  logic [DATA_W-1:0]   src1_data_i,
  output logic                src1_busy_o,
  input  logic                src2_en_i,
  input  logic [ROB_ID_W-1:0] src2_id_ROB_i,
  input  logic [DATA_W-1:0]   src2_data_i,
  output logic                src2_busy_o,
  input  logic                src3_en_i,
  input  logic [ROB_ID_W-1:0] src3_id_ROB_i,
  input  logic [DATA_W-1:0]   src3_data_i,
  output logic                src3_busy_o,
  output logic                cdb1_en_o,
  output logic [ROB_ID_W-1:0] cdb1_id_ROB_o,
  output logic [DATA_W-1:0]   cdb1_data_o,
  output logic                cdb2_en_o,
  output logic [ROB_ID_W-1:0] cdb2_id_ROB_o,
  output logic [DATA_W-1:0]   cdb2_data_o,
  output logic                cdb3_en_o,
  output logic [ROB_ID_W-1:0] cdb3_id_ROB_o,
  output logic [DATA_W-1:0]   cdb3_data_o
);
  localparam int EW = ROB_ID_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [NUM_SRC-1:0]  w_en, w_busy, w_empty, w_elig, w_byp, w_grant, w_push, w_pop;
  logic [EW-1:0]       w_in     [NUM_SRC];
  logic [EW-1:0]       w_head   [NUM_SRC];
  logic [CW-1:0]       w_count  [NUM_SRC];
  logic [NUM_LANE-1:0] w_lane_vld;
  logic [1:0]          w_lane_src   [NUM_LANE];
  logic [EW-1:0]       w_lane_entry [NUM_LANE];
  logic [1:0]          w_last;
  logic                w_any;

  logic [1:0]          r_rr;
  logic [NUM_LANE-1:0] r_lane_en;
  logic [ROB_ID_W-1:0] r_lane_id   [NUM_LANE];
  logic [DATA_W-1:0]   r_lane_data [NUM_LANE];

  assign w_en  = {src3_en_i, src2_en_i, src1_en_i, src0_en_i};
  assign w_in[0] = {src0_id_ROB_i, src0_data_i};
  assign w_in[1] = {src1_id_ROB_i, src1_data_i};
  assign w_in[2] = {src2_id_ROB_i, src2_data_i};
  assign w_in[3] = {src3_id_ROB_i, src3_data_i};

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_busy[k]  = (w_count[k] == FULL_CNT);
    assign w_empty[k] = (w_count[k] == '0);
`ifdef CDB_BYPASS_EN
    // An empty FIFO can forward its live input, which keeps per-source order.
    assign w_byp[k]  = w_empty[k] & w_en[k];
`else
    assign w_byp[k]  = 1'b0;
`endif
    assign w_elig[k] = ~w_empty[k] | w_byp[k];
    assign w_pop[k]  = rdy & ~rst_c & w_grant[k] & ~w_byp[k];
    assign w_push[k] = rdy & ~rst_c & w_en[k] & ~w_busy[k] & ~(w_grant[k] & w_byp[k]);

    cdb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (rst_c),
      .i_push  (w_push[k]),
      .i_pop   (w_pop[k]),
      .i_data  (w_in[k]),
      .o_head  (w_head[k]),
      .o_count (w_count[k])
    );
  end

  // Round-robin scan from r_rr, handing up to three grants to lanes in order.
  always_comb begin : arb_p
    logic [1:0] idx;
    logic [1:0] n;
    w_grant    = '0;
    w_lane_vld = '0;
    w_lane_src = '{default: 2'd0};
    w_last     = r_rr;
    n          = 2'd0;
    idx        = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = r_rr + i[1:0];
      if (w_elig[idx] && (n < 2'd3)) begin
        w_grant[idx]  = 1'b1;
        w_lane_vld[n] = 1'b1;
        w_lane_src[n] = idx;
        w_last        = idx;
        n             = n + 2'd1;
      end else begin
        w_grant[idx]  = 1'b0;
      end
    end
    w_any = |w_grant;
  end

  // Select each lane's payload from its granted FIFO head or bypassed input.
  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      w_lane_entry[l] = w_byp[w_lane_src[l]] ? w_in[w_lane_src[l]] : w_head[w_lane_src[l]];
    end
  end

  // Lane output registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr        <= 2'd0;
      r_lane_en   <= '0;
      r_lane_id   <= '{default: '0};
      r_lane_data <= '{default: '0};
    end else if (rst_c) begin
      r_rr        <= 2'd0;
      r_lane_en   <= '0;
      r_lane_id   <= '{default: '0};
      r_lane_data <= '{default: '0};
    end else if (rdy) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        r_lane_en[l]   <= w_lane_vld[l];
        r_lane_id[l]   <= w_lane_vld[l] ? w_lane_entry[l][EW-1 -: ROB_ID_W] : '0;
        r_lane_data[l] <= w_lane_vld[l] ? w_lane_entry[l][DATA_W-1:0] : '0;
      end
      r_rr <= w_any ? rr_next(w_last) : r_rr;
    end else begin
      r_rr <= r_rr;
    end
  end

  assign {src3_busy_o, src2_busy_o, src1_busy_o, src0_busy_o} = w_busy;
  assign cdb1_en_o = r_lane_en[0];  assign cdb1_id_ROB_o = r_lane_id[0];  assign cdb1_data_o = r_lane_data[0];
  assign cdb2_en_o = r_lane_en[1];  assign cdb2_id_ROB_o = r_lane_id[1];  assign cdb2_data_o = r_lane_data[1];
  assign cdb3_en_o = r_lane_en[2];  assign cdb3_id_ROB_o = r_lane_id[2];  assign cdb3_data_o = r_lane_data[2];
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, rst_c, rdy;
  logic [3:0]  en;
  logic [4:0]  id   [4];
  logic [31:0] data [4];
  wire  [2:0]  o_en;
  wire  [4:0]  o_id   [3];
  wire  [31:0] o_data [3];
  wire  [3:0]  o_busy;

  int checks = 0;
  int errors = 0;

  cdb_entry_t mq [4][$];
  cdb_entry_t m_lane [3];
  logic [2:0] m_en;
  int         m_rr;

  always #5 clk = ~clk;

  cdb_arbiter #(.DATA_W(32), .ROB_ID_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rst_c(rst_c), .rdy(rdy),
    .src0_en_i(en[0]), .src0_id_ROB_i(id[0]), .src0_data_i(data[0]), .src0_busy_o(o_busy[0]),
    .src1_en_i(en[1]), .src1_id_ROB_i(id[1]), .src1_data_i(data[1]), .src1_busy_o(o_busy[1]),
    .src2_en_i(en[2]), .src2_id_ROB_i(id[2]), .src2_data_i(data[2]), .src2_busy_o(o_busy[2]),
    .src3_en_i(en[3]), .src3_id_ROB_i(id[3]), .src3_data_i(data[3]), .src3_busy_o(o_busy[3]),
    .cdb1_en_o(o_en[0]), .cdb1_id_ROB_o(o_id[0]), .cdb1_data_o(o_data[0]),
    .cdb2_en_o(o_en[1]), .cdb2_id_ROB_o(o_id[1]), .cdb2_data_o(o_data[1]),
    .cdb3_en_o(o_en[2]), .cdb3_id_ROB_o(o_id[2]), .cdb3_data_o(o_data[2])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mq[k].delete();
    for (int l = 0; l < 3; l++) m_lane[l] = '0;
    m_en = 3'b000;
    m_rr = 0;
  endtask

  // One clock edge of the reference: queues in, up to three winners out.
  task automatic model_edge();
    bit busy_b [4];
    bit byp_g [4];
    int nl;
    int last;
    if (rst_c) begin
      model_clear();
    end else if (rdy) begin
      nl = 0;
      last = -1;
      for (int k = 0; k < 4; k++) begin
        busy_b[k] = (mq[k].size() == DEPTH);
        byp_g[k]  = 1'b0;
      end
      for (int l = 0; l < 3; l++) m_lane[l] = '0;
      m_en = 3'b000;
      for (int i = 0; i < 4; i++) begin
        int  s;
        bit  has;
        bit  b;
        s   = (m_rr + i) % 4;
        has = (mq[s].size() > 0);
        b   = 1'b0;
`ifdef CDB_BYPASS_EN
        b   = !has && en[s];
`endif
        if ((has || b) && nl < 3) begin
          m_lane[nl] = has ? mq[s].pop_front() : cdb_entry_t'({id[s], data[s]});
          m_en[nl]   = 1'b1;
          byp_g[s]   = b;
          nl++;
          last = s;
        end
      end
      if (last >= 0) m_rr = (last + 1) % 4;
      for (int k = 0; k < 4; k++)
        if (en[k] && !busy_b[k] && !byp_g[k]) mq[k].push_back(cdb_entry_t'({id[k], data[k]}));
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] mb;
    for (int k = 0; k < 4; k++) mb[k] = (mq[k].size() == DEPTH);
    chk({tag, " lane_en"}, 64'(o_en), 64'(m_en));
    for (int l = 0; l < 3; l++)
      chk($sformatf("%s lane%0d", tag, l + 1), 64'({o_id[l], o_data[l]}), 64'(m_lane[l]));
    chk({tag, " busy"}, 64'(o_busy), 64'(mb));
  endtask

  task automatic do_step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_tagged(input logic [3:0] e, input int base);
    en = e;
    for (int k = 0; k < 4; k++) begin
      id[k]   = 5'(base + k);
      data[k] = 32'((base + k) * 16);
    end
  endtask

  typedef struct {
    logic [3:0] en;
    int         base;
    logic       rdy;
    logic       rst_c;
    logic [2:0] x_en;
    int         x_id1, x_id2, x_id3;
    logic [3:0] x_busy;
  } vec_t;

  vec_t tbl [23];

  initial begin
    rst = 1'b1; rst_c = 1'b0; rdy = 1'b0;
    set_tagged(4'b0000, 0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    chk("reset lane_en", 64'(o_en), 64'd0);
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset lane1", 64'({o_id[0], o_data[0]}), 64'd0);
    rst = 1'b0;
    rdy = 1'b1;

`ifndef CDB_BYPASS_EN
    tbl[0]  = '{4'b1111,  1, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[1]  = '{4'b0000,  0, 1'b1, 1'b0, 3'b111,  1,  2,  3, 4'b0000};
    tbl[2]  = '{4'b0000,  0, 1'b1, 1'b0, 3'b001,  4,  0,  0, 4'b0000};
    tbl[3]  = '{4'b0010,  5, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[4]  = '{4'b0000,  0, 1'b1, 1'b0, 3'b001,  6,  0,  0, 4'b0000};
    tbl[5]  = '{4'b1111, 10, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[6]  = '{4'b1111, 20, 1'b1, 1'b0, 3'b111, 12, 13, 10, 4'b0010};
    tbl[7]  = '{4'b1111, 30, 1'b1, 1'b0, 3'b111, 11, 22, 23, 4'b0001};
    tbl[8]  = '{4'b1111, 40, 1'b0, 1'b0, 3'b111, 11, 22, 23, 4'b0001};
    tbl[9]  = '{4'b1111, 40, 1'b0, 1'b0, 3'b111, 11, 22, 23, 4'b0001};
    tbl[10] = '{4'b1111, 40, 1'b0, 1'b0, 3'b111, 11, 22, 23, 4'b0001};
    tbl[11] = '{4'b0000,  0, 1'b1, 1'b0, 3'b111, 20, 21, 32, 4'b0000};
    tbl[12] = '{4'b0010, 50, 1'b1, 1'b1, 3'b000,  0,  0,  0, 4'b0000};
    tbl[13] = '{4'b0000,  0, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[14] = '{4'b0000,  0, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[15] = '{4'b1111, 60, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    tbl[16] = '{4'b1111, 70, 1'b1, 1'b0, 3'b111, 60, 61, 62, 4'b1000};
    tbl[17] = '{4'b0100, 80, 1'b1, 1'b0, 3'b111, 63, 70, 71, 4'b0100};
    tbl[18] = '{4'b0100, 90, 1'b0, 1'b0, 3'b111, 63, 70, 71, 4'b0100};
    tbl[19] = '{4'b0100, 90, 1'b1, 1'b0, 3'b011, 72, 73,  0, 4'b0000};
    tbl[20] = '{4'b0100, 90, 1'b1, 1'b0, 3'b001, 82,  0,  0, 4'b0000};
    tbl[21] = '{4'b0000,  0, 1'b1, 1'b0, 3'b001, 92,  0,  0, 4'b0000};
    tbl[22] = '{4'b0000,  0, 1'b1, 1'b0, 3'b000,  0,  0,  0, 4'b0000};
    for (int r = 0; r < 23; r++) begin
      set_tagged(tbl[r].en, tbl[r].base);
      rdy   = tbl[r].rdy;
      rst_c = tbl[r].rst_c;
      do_step($sformatf("row%0d model", r));
      chk($sformatf("row%0d en", r), 64'(o_en), 64'(tbl[r].x_en));
      chk($sformatf("row%0d ids", r), 64'({o_id[0], o_id[1], o_id[2]}),
          64'({5'(tbl[r].x_id1), 5'(tbl[r].x_id2), 5'(tbl[r].x_id3)}));
      chk($sformatf("row%0d busy", r), 64'(o_busy), 64'(tbl[r].x_busy));
    end
    rst_c = 1'b0; rdy = 1'b1;
`endif

    // src3 result with tag 7 into an empty FIFO: check bypass/normal latency.
    set_tagged(4'b0000, 0);
    do_step("idle");
    en = 4'b1000; id[3] = 5'd7; data[3] = 32'h0000_0777;
    do_step("lat N");
`ifdef CDB_BYPASS_EN
    chk("bypass lane1 id after N", 64'(o_id[0]), 64'd7);
    chk("bypass lane1 en after N", 64'(o_en), 64'b001);
`else
    chk("nobypass lane en after N", 64'(o_en), 64'b000);
`endif
    en = 4'b0000;
    do_step("lat N+1");
`ifndef CDB_BYPASS_EN
    chk("nobypass lane1 id after N+1", 64'(o_id[0]), 64'd7);
`endif

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        en[k]   = ($urandom_range(0, 99) < 60);
        id[k]   = 5'($urandom);
        data[k] = $urandom;
      end
      rdy   = ($urandom_range(0, 7) != 0);
      rst_c = ($urandom_range(0, 39) == 0);
      do_step($sformatf("rand%0d", c));
      if (c == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("async rst lane_en", 64'(o_en), 64'd0);
        chk("async rst busy", 64'(o_busy), 64'd0);
        chk("async rst lane1", 64'({o_id[0], o_data[0]}), 64'd0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end

    en = 4'b0000; rdy = 1'b1; rst_c = 1'b0;
    for (int c = 0; c < 6; c++) do_step($sformatf("drain%0d", c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
